instr_load_ctrl: RTL and testbench
==================================

// Module: instr_load_ctrl
// PURPOSE
//  Owns the single port of instr_memory and shares it between CPU fetch and a byte-stream
//  program loader (UART-side). In RUN the CPU address passes through; on load_req the block
//  stalls the CPU, assembles byte pairs into 16-bit words and writes them from address 0 up.
//  On completion it pulses cpu_restart so the PC returns to 0 and fetch resumes.
// PARAMETERS
//  ADDR_W     16   memory address width
//  DATA_W     16   instruction word width (two bytes)
//  MEM_DEPTH  171  words implemented in instr_memory (valid addresses 0..MEM_DEPTH-1)
// PORTS
//  clk          in   1       system clock, rising edge
//  rst_n        in   1       asynchronous, active-low reset
//  load_req     in   1       start a load; sampled only in RUN
//  word_count   in   ADDR_W  words to load; latched with load_req
//  byte_valid   in   1       loader byte present
//  byte_data    in   8       loader byte
//  byte_ready   out  1       byte accepted when byte_valid & byte_ready
//  cpu_addr     in   ADDR_W  CPU fetch address (PC)
//  mem_addr     out  ADDR_W  to instr_memory.addr
//  mem_write_en out  1       to instr_memory.write_en
//  mem_instr_in out  DATA_W  to instr_memory.instr_in
//  cpu_stall    out  1       holds CPU (PC and state frozen)
//  cpu_restart  out  1       1-cycle pulse: CPU resets PC to 0
//  load_done    out  1       1-cycle pulse: load finished without error
//  load_err     out  1       sticky: word_count > MEM_DEPTH; cleared by next accepted load_req
// BEHAVIOUR
//  - Reset: state RUN, ptr=0, hi_byte=0, byte_ready=0, mem_write_en=0, mem_instr_in=0,
//    cpu_stall=0, cpu_restart=0, load_done=0, load_err=0. Memory contents untouched.
//  - mem_addr = cpu_addr (combinational) in RUN; = ptr in every other state.
//  - States: RUN, CHECK, GET_HI, GET_LO, WRITE, FINISH.
//  - RUN: cpu_stall=0. load_req=1 -> latch word_count, clear load_err, ptr=0 -> CHECK.
//  - CHECK (1 cycle, cpu_stall=1): count>MEM_DEPTH -> load_err=1, RUN, no write, no restart;
//    count==0 -> FINISH; else GET_HI.
//  - GET_HI: byte_ready=1; on accept hi_byte<=byte_data -> GET_LO.
//  - GET_LO: byte_ready=1; on accept mem_instr_in<={hi_byte,byte_data} -> WRITE (big-endian).
//  - WRITE (exactly 1 cycle): mem_write_en=1, mem_addr=ptr, byte_ready=0; ptr<=ptr+1;
//    ptr+1==count -> FINISH else GET_HI. Max throughput: 1 word per 3 cycles.
//  - FINISH (1 cycle): cpu_stall=1, cpu_restart=1, load_done=1 -> RUN; cpu_stall drops the
//    cycle after. First fetch after release sees new ram[0] (memory read latency 1 cycle).
//  - cpu_stall=1 in all states except RUN; byte_ready=0 outside GET_HI/GET_LO.
//  - load_req outside RUN ignored; load_req held high across FINISH->RUN starts a new load.
//  - byte_valid with byte_ready=0 is not consumed (source must hold it).
//  - mem_write_en only ever asserted in WRITE and only with ptr<count<=MEM_DEPTH.
//  - Reset mid-load: immediate return to RUN; partially written words remain; no done pulse.
//  - Arithmetic: ptr and count ADDR_W unsigned; no wrap possible since count<=MEM_DEPTH.
// STRUCTURE
//  - Shared package (proc_pkg): state encoding, ADDR_W/DATA_W, MEM_DEPTH, opcode constants
//    already used by instr_memory (moved there so loader test images can reuse them).
//  - One natural sub-module: byte_pair_assembler (GET_HI/GET_LO capture + valid/ready); FSM,
//    ptr counter and address mux stay in instr_load_ctrl.
// TESTING
//  1 Reset then RUN, cpu_addr=5 -> mem_addr=5, mem_write_en=0, cpu_stall=0, byte_ready=0.
//  2 load_req, count=2, bytes 00 26 01 01 back-to-back -> writes ram[0]=0x0026, ram[1]=0x0101,
//    one mem_write_en cycle each, load_done+cpu_restart pulse once, stall released next cycle.
//  3 count=3 with byte_valid gaps of 0..4 cycles -> identical written data, no byte lost/duped.
//  4 count=172 -> load_err=1, no write, back to RUN in 2 cycles; next load count=1 clears err.
//  5 count=0 -> no write, load_done pulse 2 cycles after load_req, stall exactly 2 cycles.
//  6 rst_n low after 3 of 5 words -> RUN, all outputs at reset values, ram[0..2] new, ram[3..] old.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared processor definitions: memory geometry, loader FSM encoding and the
// instruction opcodes used by instr_memory and by loader test images.
package proc_pkg;

  localparam int ADDR_W    = 16;
  localparam int DATA_W    = 16;
  localparam int MEM_DEPTH = 171;

  // Loader FSM encoding
  localparam logic [2:0] ST_RUN    = 3'd0;
  localparam logic [2:0] ST_CHECK  = 3'd1;
  localparam logic [2:0] ST_GET_HI = 3'd2;
  localparam logic [2:0] ST_GET_LO = 3'd3;
  localparam logic [2:0] ST_WRITE  = 3'd4;
  localparam logic [2:0] ST_FINISH = 3'd5;

  // Opcodes occupy instr[15:12]
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LOAD = 4'h1;
  localparam logic [3:0] OP_STOR = 4'h2;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_SUB  = 4'h4;
  localparam logic [3:0] OP_JMP  = 4'h5;
  localparam logic [3:0] OP_JZ   = 4'h6;
  localparam logic [3:0] OP_HALT = 4'hF;

  function automatic logic [DATA_W-1:0] mk_instr(input logic [3:0] op,
                                                 input logic [11:0] arg);
    return {op, arg};
  endfunction

endpackage

// File: rtl/byte_pair_assembler.sv
// Captures a high byte then a low byte from the loader stream and presents
// the resulting big-endian word; ready is driven purely by the FSM phase.
module byte_pair_assembler
  import proc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              get_hi,
  input  logic              get_lo,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              hi_done,
  output logic              lo_done,
  output logic [DATA_W-1:0] word
);

  logic [7:0] hi_byte;

  assign byte_ready = get_hi | get_lo;
  assign hi_done    = get_hi & byte_valid;
  assign lo_done    = get_lo & byte_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_byte <= '0;
      word    <= '0;
    end else begin
      if (hi_done) hi_byte <= byte_data;
      if (lo_done) word    <= {hi_byte, byte_data};
    end
  end

endmodule

// File: rtl/instr_load_ctrl.sv
// Arbitrates the single instr_memory port between CPU fetch and the byte-stream
// program loader; stalls the CPU during a load and restarts it at PC 0.
module instr_load_ctrl
  import proc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_req,
  input  logic [ADDR_W-1:0] word_count,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_write_en,
  output logic [DATA_W-1:0] mem_instr_in,
  output logic              cpu_stall,
  output logic              cpu_restart,
  output logic              load_done,
  output logic              load_err
);

  localparam logic [ADDR_W-1:0] DEPTH = ADDR_W'(MEM_DEPTH);

  logic [2:0]        state, state_nxt;
  logic [ADDR_W-1:0] ptr, count;
  logic [ADDR_W-1:0] ptr_inc;
  logic              hi_done, lo_done;

  byte_pair_assembler u_bpa (
    .clk        (clk),
    .rst_n      (rst_n),
    .get_hi     (state == ST_GET_HI),
    .get_lo     (state == ST_GET_LO),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .hi_done    (hi_done),
    .lo_done    (lo_done),
    .word       (mem_instr_in)
  );

  assign ptr_inc = ptr + 1'b1;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:    if (load_req) state_nxt = ST_CHECK;
      ST_CHECK:  if (count > DEPTH)      state_nxt = ST_RUN;
                 else if (count == '0)   state_nxt = ST_FINISH;
                 else                    state_nxt = ST_GET_HI;
      ST_GET_HI: if (hi_done) state_nxt = ST_GET_LO;
      ST_GET_LO: if (lo_done) state_nxt = ST_WRITE;
      ST_WRITE:  state_nxt = (ptr_inc == count) ? ST_FINISH : ST_GET_HI;
      ST_FINISH: state_nxt = ST_RUN;
      default:   state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_RUN;
      ptr      <= '0;
      count    <= '0;
      load_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_RUN && load_req) begin
        count    <= word_count;
        ptr      <= '0;
        load_err <= 1'b0;
      end
      // Oversized image is rejected before anything touches memory
      if (state == ST_CHECK && count > DEPTH) load_err <= 1'b1;
      if (state == ST_WRITE) ptr <= ptr_inc;
    end
  end

  assign mem_addr     = (state == ST_RUN) ? cpu_addr : ptr;
  assign mem_write_en = (state == ST_WRITE);
  assign cpu_stall    = (state != ST_RUN);
  assign cpu_restart  = (state == ST_FINISH);
  assign load_done    = (state == ST_FINISH);

endmodule

// File: tb/tb_instr_load_ctrl.sv
// Directed bench for instr_load_ctrl with a behavioural instr_memory model.
module tb_instr_load_ctrl;
  import proc_pkg::*;

  logic              clk = 0, rst_n = 0;
  logic              load_req = 0;
  logic [ADDR_W-1:0] word_count = '0;
  logic              byte_valid = 0;
  logic [7:0]        byte_data = '0;
  logic              byte_ready;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_write_en;
  logic [DATA_W-1:0] mem_instr_in;
  logic              cpu_stall, cpu_restart, load_done, load_err;

  int nvec = 0, nmis = 0;
  int wr_cnt = 0, done_cnt = 0, rst_cnt = 0, stall_cnt = 0, acc_cnt = 0, bad_wr = 0;
  logic [DATA_W-1:0] ram [MEM_DEPTH];

  always #5 clk = ~clk;

  instr_load_ctrl dut (
    .clk(clk), .rst_n(rst_n), .load_req(load_req), .word_count(word_count),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .cpu_addr(cpu_addr), .mem_addr(mem_addr), .mem_write_en(mem_write_en),
    .mem_instr_in(mem_instr_in), .cpu_stall(cpu_stall), .cpu_restart(cpu_restart),
    .load_done(load_done), .load_err(load_err)
  );

  initial for (int i = 0; i < MEM_DEPTH; i++) ram[i] = 16'hF000 + 16'(i);

  always @(posedge clk) begin
    if (mem_write_en) begin
      if (mem_addr < ADDR_W'(MEM_DEPTH)) ram[mem_addr] <= mem_instr_in;
      else bad_wr <= bad_wr + 1;
      wr_cnt <= wr_cnt + 1;
    end
    if (load_done)   done_cnt  <= done_cnt + 1;
    if (cpu_restart) rst_cnt   <= rst_cnt + 1;
    if (cpu_stall)   stall_cnt <= stall_cnt + 1;
    if (byte_valid && byte_ready) acc_cnt <= acc_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge following acceptance
  task automatic send_byte(input logic [7:0] b, input int gap);
    int t = 0;
    repeat (gap) begin byte_valid = 0; @(negedge clk); end
    byte_valid = 1; byte_data = b;
    while (!byte_ready && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) chk("byte_timeout", 0, 1);
    @(negedge clk);
    byte_valid = 0;
  endtask

  task automatic start_load(input logic [15:0] n);
    load_req = 1; word_count = n;
    @(negedge clk);
    load_req = 0;
  endtask

  // Waits for the done pulse, checks it and the stall release on the next cycle
  task automatic wait_done(input string tag);
    int t = 0;
    while (!load_done && t < 50) begin @(negedge clk); t++; end
    chk({tag, "_done_seen"}, 32'(load_done), 1);
    chk({tag, "_restart"}, 32'(cpu_restart), 1);
    chk({tag, "_stall_fin"}, 32'(cpu_stall), 1);
    @(negedge clk);
    chk({tag, "_stall_rel"}, 32'(cpu_stall), 0);
  endtask

  int w0, d0, s0, a0;
  logic [7:0] bytes3 [6] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
  int gaps3 [6] = '{0, 1, 2, 3, 4, 2};

  initial begin
    // 1: reset / RUN pass-through
    cpu_addr = 16'd5;
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("t1_addr", 32'(mem_addr), 5);
    chk("t1_we", 32'(mem_write_en), 0);
    chk("t1_stall", 32'(cpu_stall), 0);
    chk("t1_ready", 32'(byte_ready), 0);
    chk("t1_err", 32'(load_err), 0);

    // 2: two words, back-to-back bytes
    start_load(16'd2);
    chk("t2_stall_check", 32'(cpu_stall), 1);
    chk("t2_addr_ptr", 32'(mem_addr), 0);
    send_byte(8'h00, 0); send_byte(8'h26, 0);
    send_byte(8'h01, 0); send_byte(8'h01, 0);
    wait_done("t2");
    chk("t2_ram0", 32'(ram[0]), 32'h0026);
    chk("t2_ram1", 32'(ram[1]), 32'h0101);
    chk("t2_wr_cnt", wr_cnt, 2);
    chk("t2_done_cnt", done_cnt, 1);
    chk("t2_restart_cnt", rst_cnt, 1);
    chk("t2_addr_run", 32'(mem_addr), 5);

    // 3: three words with source gaps
    w0 = wr_cnt; a0 = acc_cnt;
    start_load(16'd3);
    for (int i = 0; i < 6; i++) send_byte(bytes3[i], gaps3[i]);
    wait_done("t3");
    chk("t3_ram0", 32'(ram[0]), 32'h1234);
    chk("t3_ram1", 32'(ram[1]), 32'h5678);
    chk("t3_ram2", 32'(ram[2]), 32'h9ABC);
    chk("t3_wr", wr_cnt - w0, 3);
    chk("t3_acc", acc_cnt - a0, 6);

    // 4: oversized count, then a good load clears the error
    w0 = wr_cnt; d0 = done_cnt;
    start_load(16'd172);
    chk("t4_stall_check", 32'(cpu_stall), 1);
    @(negedge clk);
    chk("t4_err", 32'(load_err), 1);
    chk("t4_run", 32'(cpu_stall), 0);
    chk("t4_no_wr", wr_cnt - w0, 0);
    chk("t4_no_done", done_cnt - d0, 0);
    start_load(16'd1);
    chk("t4_err_clr", 32'(load_err), 0);
    send_byte(8'hAB, 0); send_byte(8'hCD, 1);
    wait_done("t4");
    chk("t4_ram0", 32'(ram[0]), 32'hABCD);

    // 5: zero-length load
    w0 = wr_cnt; s0 = stall_cnt; d0 = done_cnt;
    start_load(16'd0);
    chk("t5_done_early", 32'(load_done), 0);
    @(negedge clk);
    chk("t5_done_2cyc", 32'(load_done), 1);
    @(negedge clk);
    chk("t5_stall_cycles", stall_cnt - s0, 2);
    chk("t5_no_wr", wr_cnt - w0, 0);
    chk("t5_done_cnt", done_cnt - d0, 1);

    // 6: reset after 3 of 5 words
    w0 = wr_cnt; d0 = done_cnt;
    start_load(16'd5);
    send_byte(8'h11, 0); send_byte(8'h11, 0);
    send_byte(8'h22, 0); send_byte(8'h22, 0);
    send_byte(8'h33, 0); send_byte(8'h33, 0);
    @(negedge clk);
    rst_n = 0;
    #1;
    chk("t6_stall", 32'(cpu_stall), 0);
    chk("t6_ready", 32'(byte_ready), 0);
    chk("t6_we", 32'(mem_write_en), 0);
    chk("t6_addr", 32'(mem_addr), 5);
    chk("t6_instr", 32'(mem_instr_in), 0);
    chk("t6_done", 32'(load_done), 0);
    @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);
    chk("t6_ram0", 32'(ram[0]), 32'h1111);
    chk("t6_ram1", 32'(ram[1]), 32'h2222);
    chk("t6_ram2", 32'(ram[2]), 32'h3333);
    chk("t6_ram3_old", 32'(ram[3]), 32'hF003);
    chk("t6_wr", wr_cnt - w0, 3);
    chk("t6_no_done", done_cnt - d0, 0);
    chk("t6_run", 32'(cpu_stall), 0);
    chk("bad_addr_writes", bad_wr, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
